ysyx_22040750_clint: RTL and testbench

- Core-local interruptor: holds the 64-bit mtime counter and the mtimecmp compare register.
- Drives the machine-timer-pending level into the CSR unit's I_mtip input. The CSR unit latches it into mip[7] and raises O_timer_intr when mie[7] and mstatus.MIE are set.
- Memory-mapped behind the LSU on a single-outstanding valid/ready request/response port.
- mtime advances every TICK_DIV clocks.

---
 rtl/ysyx_22040750_clint.sv | 134 +++++++++++++
 tb/tb_ysyx_22040750_clint.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040750_clint.sv
// rtl/ysyx_22040750_clint.sv - core-local interruptor: mtime/mtimecmp with a single-outstanding request/response port
module ysyx_22040750_clint #(
  parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
  parameter logic [15:0] MTIMECMP_OFF = 16'h4000,
  parameter logic [15:0] MTIME_OFF    = 16'hBFF8,
  parameter int unsigned TICK_DIV     = 1
) (
  input  logic        I_sys_clk,
  input  logic        I_rst_n,
  input  logic        I_req_valid,
  output logic        O_req_ready,
  input  logic        I_req_wen,
  input  logic [31:0] I_req_addr,
  input  logic [63:0] I_req_wdata,
  input  logic [7:0]  I_req_wmask,
  output logic        O_resp_valid,
  input  logic        I_resp_ready,
  output logic [63:0] O_resp_rdata,
  output logic        O_resp_err,
  output logic        O_mtip
);

  localparam int unsigned PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [31:0] MTIME_ADDR    = BASE_ADDR + {16'h0000, MTIME_OFF};
  localparam logic [31:0] MTIMECMP_ADDR = BASE_ADDR + {16'h0000, MTIMECMP_OFF};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_e;

  state_e        state_q;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q;
  logic          mtip_q;

  logic accept;
  logic hit_mtime;
  logic hit_cmp;
  logic tick;
  logic unused_addr_lo;

  // The low address bits only select a byte inside the 8-byte register.
  assign unused_addr_lo = ^I_req_addr[2:0];

  // Byte-lane merge of write data into an existing 64-bit register value.
  function automatic logic [63:0] lane_merge(input logic [63:0] old_val,
                                             input logic [63:0] wdata,
                                             input logic [7:0]  wmask);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (wmask[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  // Decode, prescaler and next-state values for the timer registers.
  always_comb begin
    accept     = (state_q == S_IDLE) && I_req_valid;
    hit_mtime  = (I_req_addr[31:3] == MTIME_ADDR[31:3]);
    hit_cmp    = (I_req_addr[31:3] == MTIMECMP_ADDR[31:3]);
    tick       = (presc_q == PRESC_LAST);
    presc_d    = tick ? '0 : presc_q + PW'(1);
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    rdata_d    = 64'd0;
    if (accept && I_req_wen && hit_mtime) begin
      // A bus write wins over the increment of the same clock.
      mtime_d = lane_merge(mtime_q, I_req_wdata, I_req_wmask);
    end
    if (accept && I_req_wen && hit_cmp) begin
      mtimecmp_d = lane_merge(mtimecmp_q, I_req_wdata, I_req_wmask);
    end
    if (!I_req_wen && hit_mtime) begin
      rdata_d = mtime_q;
    end else if (!I_req_wen && hit_cmp) begin
      rdata_d = mtimecmp_q;
    end
  end

  // Timer registers and the registered timer-pending level.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      presc_q    <= '0;
      mtip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      mtip_q     <= (mtime_d >= mtimecmp_d);
    end
  end

  // Handshake FSM: capture the response on accept, hold it until taken.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= S_IDLE;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (I_req_valid) begin
            state_q <= S_RESP;
            rdata_q <= rdata_d;
            err_q   <= !(hit_mtime || hit_cmp);
          end
        end
        S_RESP: begin
          if (I_resp_ready) begin
            state_q <= S_IDLE;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign O_req_ready  = (state_q == S_IDLE);
  assign O_resp_valid = (state_q == S_RESP);
  assign O_resp_rdata = rdata_q;
  assign O_resp_err   = err_q;
  assign O_mtip       = mtip_q;

endmodule

// File: tb/tb_ysyx_22040750_clint.sv
// tb/tb_ysyx_22040750_clint.sv - directed, table-driven bench for ysyx_22040750_clint (TICK_DIV 1 and 4)
module tb_ysyx_22040750_clint;

  localparam logic [31:0] A_MTIME = 32'h0200_BFF8;
  localparam logic [31:0] A_CMP   = 32'h0200_4000;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_ready;

  logic        req_ready1, resp_valid1, err1, mtip1;
  logic [63:0] rdata1;
  logic        req_ready4, resp_valid4, err4, mtip4;
  logic [63:0] rdata4;

  ysyx_22040750_clint #(.TICK_DIV(1)) u_dut1 (
    .I_sys_clk   (clk),
    .I_rst_n     (rst_n),
    .I_req_valid (req_valid),
    .O_req_ready (req_ready1),
    .I_req_wen   (req_wen),
    .I_req_addr  (req_addr),
    .I_req_wdata (req_wdata),
    .I_req_wmask (req_wmask),
    .O_resp_valid(resp_valid1),
    .I_resp_ready(resp_ready),
    .O_resp_rdata(rdata1),
    .O_resp_err  (err1),
    .O_mtip      (mtip1)
  );

  ysyx_22040750_clint #(.TICK_DIV(4)) u_dut4 (
    .I_sys_clk   (clk),
    .I_rst_n     (rst_n),
    .I_req_valid (req_valid),
    .O_req_ready (req_ready4),
    .I_req_wen   (req_wen),
    .I_req_addr  (req_addr),
    .I_req_wdata (req_wdata),
    .I_req_wmask (req_wmask),
    .O_resp_valid(resp_valid4),
    .I_resp_ready(resp_ready),
    .O_resp_rdata(rdata4),
    .O_resp_err  (err4),
    .O_mtip      (mtip4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of both timers (shared mtimecmp since the bus is shared).
  logic [63:0] m1, m4, cmp;
  int          p4;
  logic        pw, pw_mtime;
  logic [63:0] pw_data;
  logic [7:0]  pw_mask;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] m);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (pw && pw_mtime) begin
      m1 = merge(m1, pw_data, pw_mask);
      m4 = merge(m4, pw_data, pw_mask);
    end else begin
      m1 = m1 + 64'd1;
      if (p4 == 3) m4 = m4 + 64'd1;
    end
    p4 = (p4 + 1) % 4;
    if (pw && !pw_mtime) cmp = merge(cmp, pw_data, pw_mask);
    pw = 1'b0;
    #1;
    chk("mtip1", {63'd0, mtip1}, {63'd0, (m1 >= cmp)});
    chk("mtip4", {63'd0, mtip4}, {63'd0, (m4 >= cmp)});
  endtask

  task automatic bus(input logic wen, input logic [31:0] addr, input logic [63:0] wdata,
                     input logic [7:0] wmask, input int stall,
                     output logic [63:0] r1, output logic [63:0] r4,
                     output logic e1, output logic e4);
    chk("req_ready_idle", {63'd0, req_ready1}, 64'd1);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    if (wen && addr[31:3] == A_MTIME[31:3]) begin
      pw = 1'b1; pw_mtime = 1'b1; pw_data = wdata; pw_mask = wmask;
    end else if (wen && addr[31:3] == A_CMP[31:3]) begin
      pw = 1'b1; pw_mtime = 1'b0; pw_data = wdata; pw_mask = wmask;
    end
    tick();
    req_valid = 1'b0;
    chk("resp_valid", {63'd0, resp_valid1}, 64'd1);
    chk("req_ready_busy", {63'd0, req_ready1}, 64'd0);
    r1 = rdata1; r4 = rdata4; e1 = err1; e4 = err4;
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_resp_valid", {63'd0, resp_valid1}, 64'd1);
      chk("stall_req_ready", {63'd0, req_ready1}, 64'd0);
      chk("stall_rdata", rdata1, r1);
      chk("stall_err", {63'd0, err1}, {63'd0, e1});
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("resp_done", {63'd0, resp_valid1}, 64'd0);
    chk("ready_again", {63'd0, req_ready1}, 64'd1);
  endtask

  task automatic rd_mtime(input string name);
    logic [63:0] e1v, e4v, r1, r4;
    logic        x1, x4;
    e1v = m1;
    e4v = m4;
    bus(1'b0, A_MTIME, 64'd0, 8'h00, 0, r1, r4, x1, x4);
    chk({name, "_1"}, r1, e1v);
    chk({name, "_4"}, r4, e4v);
    chk({name, "_err"}, {63'd0, x1}, 64'd0);
  endtask

  initial begin
    logic [63:0] r1, r4;
    logic        e1, e4;
    int          k;

    vecs[0]  = '{1'b1, 32'h0200_4000, 64'h1111_1111_2222_2222, 8'h0F, 64'd0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0200_4000, 64'd0, 8'h00, 64'hFFFF_FFFF_2222_2222, 1'b0};
    vecs[2]  = '{1'b1, 32'h0200_4005, 64'h3333_3333_4444_4444, 8'hF0, 64'd0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0200_4007, 64'd0, 8'h00, 64'h3333_3333_2222_2222, 1'b0};
    vecs[4]  = '{1'b1, 32'h0200_4000, 64'h0, 8'h00, 64'd0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0200_4000, 64'd0, 8'h00, 64'h3333_3333_2222_2222, 1'b0};
    vecs[6]  = '{1'b1, 32'h0200_4008, 64'h0, 8'hFF, 64'd0, 1'b1};
    vecs[7]  = '{1'b0, 32'h0200_4000, 64'd0, 8'h00, 64'h3333_3333_2222_2222, 1'b0};
    vecs[8]  = '{1'b0, 32'h0200_0000, 64'd0, 8'h00, 64'd0, 1'b1};
    vecs[9]  = '{1'b0, 32'h0200_BFF0, 64'd0, 8'h00, 64'd0, 1'b1};
    vecs[10] = '{1'b1, 32'h0200_4000, 64'hAA00_0000_0000_00BB, 8'h81, 64'd0, 1'b0};
    vecs[11] = '{1'b0, 32'h0200_4000, 64'd0, 8'h00, 64'hAA33_3333_2222_22BB, 1'b0};
    vecs[12] = '{1'b1, 32'h0200_4000, ONES, 8'hFF, 64'd0, 1'b0};
    vecs[13] = '{1'b0, 32'h0200_4000, 64'd0, 8'h00, ONES, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'd0;
    req_wdata = 64'd0; req_wmask = 8'd0; resp_ready = 1'b0;
    m1 = 64'd0; m4 = 64'd0; cmp = ONES; p4 = 0;
    pw = 1'b0; pw_mtime = 1'b0; pw_data = 64'd0; pw_mask = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mtip", {63'd0, mtip1}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid1}, 64'd0);
    chk("rst_rdata", rdata1, 64'd0);
    chk("rst_err", {63'd0, err1}, 64'd0);
    rst_n = 1'b1;
    chk("rst_req_ready", {63'd0, req_ready1}, 64'd1);

    // 1: mtime reads 0 right after reset, then N after N clocks
    rd_mtime("mtime_first");
    chk("mtime_first_lit", r1, r1);
    repeat (3) tick();
    bus(1'b0, A_MTIME, 64'd0, 8'h00, 0, r1, r4, e1, e4);
    chk("mtime_n5_div1", r1, 64'd5);
    chk("mtime_n5_div4", r4, 64'd1);
    chk("mtime_n5_err", {63'd0, e1}, 64'd0);

    // 2: mtimecmp=20, mtip rises when mtime reaches 20
    bus(1'b1, A_CMP, 64'd20, 8'hFF, 0, r1, r4, e1, e4);
    k = 0;
    while (!mtip1 && k < 40) begin
      tick();
      k++;
    end
    chk("mtip_rise_seen", {63'd0, mtip1}, 64'd1);
    bus(1'b0, A_MTIME, 64'd0, 8'h00, 0, r1, r4, e1, e4);
    chk("mtime_at_rise", r1, 64'd20);
    repeat (3) tick();
    chk("mtip_stays", {63'd0, mtip1}, 64'd1);

    // 3: raising mtimecmp clears mtip
    bus(1'b1, A_CMP, ONES, 8'hFF, 0, r1, r4, e1, e4);
    chk("mtip_cleared", {63'd0, mtip1}, 64'd0);
    bus(1'b0, A_CMP, 64'd0, 8'h00, 0, r1, r4, e1, e4);
    chk("cmp_ones_rb", r1, ONES);

    // 4: mtime wrap with mtimecmp all ones
    bus(1'b1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, r1, r4, e1, e4);
    chk("wrap_mtip_hi", {63'd0, mtip1}, 64'd1);
    tick();
    chk("wrap_mtip_lo", {63'd0, mtip1}, 64'd0);
    bus(1'b0, A_MTIME, 64'd0, 8'h00, 0, r1, r4, e1, e4);
    chk("wrap_mtime_zero", r1, 64'd0);

    // 5: table of mtimecmp partial writes and decode misses
    for (int v = 0; v < 14; v++) begin
      bus(vecs[v].wen, vecs[v].addr, vecs[v].wdata, vecs[v].wmask, 0, r1, r4, e1, e4);
      chk($sformatf("vec%0d_rdata1", v), r1, vecs[v].exp_rdata);
      chk($sformatf("vec%0d_rdata4", v), r4, vecs[v].exp_rdata);
      chk($sformatf("vec%0d_err1", v), {63'd0, e1}, {63'd0, vecs[v].exp_err});
      chk($sformatf("vec%0d_err4", v), {63'd0, e4}, {63'd0, vecs[v].exp_err});
    end

    // 6: stalled miss response, then TICK_DIV=4 cadence
    bus(1'b0, 32'h0200_0008, 64'd0, 8'h00, 3, r1, r4, e1, e4);
    chk("miss_err", {63'd0, e1}, 64'd1);
    chk("miss_rdata", r1, 64'd0);
    bus(1'b0, A_CMP, 64'd0, 8'h00, 0, r1, r4, e1, e4);
    chk("miss_cmp_kept", r1, ONES);
    rd_mtime("mtime_after_miss");
    bus(1'b1, A_MTIME, 64'd0, 8'hFF, 0, r1, r4, e1, e4);
    repeat (9) tick();
    rd_mtime("div4_cadence_a");
    repeat (5) tick();
    rd_mtime("div4_cadence_b");

    // Reset in the middle of a transaction aborts it
    req_valid = 1'b1; req_wen = 1'b0; req_addr = A_MTIME;
    tick();
    req_valid = 1'b0;
    chk("abort_pre_valid", {63'd0, resp_valid1}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_resp_valid", {63'd0, resp_valid1}, 64'd0);
    chk("abort_rdata", rdata1, 64'd0);
    chk("abort_req_ready", {63'd0, req_ready1}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
